rom_loader_rx: RTL



---
 rtl/rom_loader_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader_rx.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_rx
// Purpose  : Receiving end of the ROM loading link. Accepts instruction words
//            over the four-phase load/sck/data/ack handshake and writes them
//            at consecutive addresses from 0 through the ROM controller's
//            write port. 'loading' holds the CPU in reset during a session.
// Options  : ROM_LOADER_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH
//            checksum output of the words written in the session.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader_rx #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rom_loader_load,
    input  logic                     rom_loader_sck,
    input  logic [DATA_WIDTH-1:0]    rom_loader_data,
    output logic                     rom_loader_ack,
    output logic                     mem_write_req,
    output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic                     mem_write_done,
    output logic                     loading,
    output logic [ADDRESS_WIDTH:0]   word_count,
    output logic                     overflow
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    // Saturation ceiling of word_count is exactly 2^ADDRESS_WIDTH.
    localparam logic [ADDRESS_WIDTH:0]   WC_MAX   = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   WC_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SCK = 2'd1,
        ST_WRITE    = 2'd2,
        ST_ACK      = 2'd3
    } state_t;

    state_t                   state;
    logic                     load_meta;
    logic                     load_s;
    logic                     sck_meta;
    logic                     sck_s;
    logic                     sck_d;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     sck_rise;
    logic                     addr_last;

    assign sck_rise  = sck_s & ~sck_d;
    assign addr_last = &addr;

    // Two-flop synchronizers for the asynchronous loader pins plus one extra
    // sck stage for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_meta <= 1'b0;
            load_s    <= 1'b0;
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            load_meta <= rom_loader_load;
            load_s    <= load_meta;
            sck_meta  <= rom_loader_sck;
            sck_s     <= sck_meta;
            sck_d     <= sck_s;
        end
    end

    // Session FSM with registered outputs; counters hold their values in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rom_loader_ack <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            loading        <= 1'b0;
            word_count     <= '0;
            overflow       <= 1'b0;
            addr           <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    rom_loader_ack <= 1'b0;
                    loading        <= 1'b0;
                    if (load_s) begin
                        addr       <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        loading    <= 1'b1;
                        state      <= ST_WAIT_SCK;
                    end
                end
                ST_WAIT_SCK: begin
                    if (!load_s) begin
                        loading <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (sck_rise) begin
                        mem_write_data <= rom_loader_data;
                        mem_write_addr <= addr;
                        mem_write_req  <= 1'b1;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // A load drop is only acted on once the write completes,
                    // and that word then receives no acknowledge.
                    if (mem_write_done) begin
                        mem_write_req <= 1'b0;
                        addr          <= addr + ADDR_ONE;
                        if (addr_last) begin
                            overflow <= 1'b1;
                        end
                        if (word_count != WC_MAX) begin
                            word_count <= word_count + WC_ONE;
                        end
`ifdef ROM_LOADER_CHECKSUM_EN
                        checksum <= checksum + mem_write_data;
`endif
                        if (load_s) begin
                            rom_loader_ack <= 1'b1;
                            state          <= ST_ACK;
                        end else begin
                            loading <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_ACK: begin
                    if (!load_s) begin
                        rom_loader_ack <= 1'b0;
                        loading        <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (!sck_s) begin
                        rom_loader_ack <= 1'b0;
                        state          <= ST_WAIT_SCK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
